// File: rtl/calc_engine.sv
// calc_engine: keypad calculator core. It edge-detects digit and operator
// presses, builds a decimal operand and evaluates chained unsigned
// add/sub/mul/div. Multiply (shift-add) and divide (restoring) retire one
// bit per cycle.
module calc_engine #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       btn,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] displayedNum,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int IW = $clog2(WIDTH + 1);

  localparam logic [2:0] OPC_NONE = 3'd0;
  localparam logic [2:0] OPC_EQ   = 3'd1;
  localparam logic [2:0] OPC_ADD  = 3'd2;
  localparam logic [2:0] OPC_SUB  = 3'd3;
  localparam logic [2:0] OPC_MUL  = 3'd4;
  localparam logic [2:0] OPC_DIV  = 3'd5;
  localparam logic [2:0] OPC_CE   = 3'd6;
  localparam logic [2:0] OPC_CA   = 3'd7;

  typedef enum logic [1:0] {S_ENTRY, S_CALC, S_RESULT, S_ERROR} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d, entry_q, entry_d, disp_q, disp_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d, quot_q, quot_d, rem_q, rem_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [2:0]         pend_q, pend_d, next_op_q, next_op_d, op_prev_q, op_prev_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      iter_q, iter_d;
  logic [9:0]         btn_prev_q, btn_prev_d;
  logic               busy_q, busy_d, err_q, err_d;

  logic               digit_hit, op_hit, clear_all, start_eval, fin, ovf;
  logic [3:0]         dig;
  logic [WIDTH-1:0]   entry_next, res;
  logic [WIDTH:0]     sum, rem_sh;

  // A digit press is a rising edge of exactly one key; chords are ignored.
  assign digit_hit  = (btn_prev_q == 10'd0) && (btn != 10'd0) && ((btn & (btn - 10'd1)) == 10'd0);
  assign op_hit     = (op_prev_q == OPC_NONE) && (opcode != OPC_NONE);
  assign entry_next = (entry_q << 3) + (entry_q << 1) + {{(WIDTH-4){1'b0}}, dig};
  assign sum        = {1'b0, acc_q} + {1'b0, entry_q};
  assign rem_sh     = {rem_q, quot_q[WIDTH-1]};

  // Encode the one-hot digit key into its decimal value.
  always_comb begin
    dig = 4'd0;
    for (int i = 0; i < 10; i++)
      if (btn[i]) dig = 4'(i);
  end

  // Next-state logic: key handling, evaluation sequencing and completion.
  always_comb begin
    state_d = state_q;  acc_d = acc_q;  entry_d = entry_q;  disp_d = disp_q;
    mplier_d = mplier_q;  quot_d = quot_q;  rem_d = rem_q;
    mcand_d = mcand_q;  prod_d = prod_q;  pend_d = pend_q;  next_op_d = next_op_q;
    cnt_d = cnt_q;  iter_d = iter_q;  busy_d = busy_q;  err_d = err_q;
    btn_prev_d = btn;  op_prev_d = opcode;
    clear_all = 1'b0;  start_eval = 1'b0;  fin = 1'b0;  ovf = 1'b0;  res = '0;

    case (state_q)
      S_CALC: begin
        // Presses are dropped here; divide by zero is caught before iterating.
        if (pend_q == OPC_DIV && entry_q == '0) begin
          fin = 1'b1;  ovf = 1'b1;
        end else if (pend_q == OPC_ADD) begin
          fin = 1'b1;  res = sum[WIDTH-1:0];  ovf = sum[WIDTH];
        end else if (pend_q == OPC_SUB) begin
          fin = 1'b1;  res = acc_q - entry_q;  ovf = (acc_q < entry_q);
        end else if (iter_q != IW'(WIDTH)) begin
          iter_d = iter_q + 1'b1;
          if (pend_q == OPC_MUL) begin
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end else if (rem_sh >= {1'b0, entry_q}) begin
            rem_d  = WIDTH'(rem_sh - {1'b0, entry_q});
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = rem_sh[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
          end
        end else if (pend_q == OPC_MUL) begin
          fin = 1'b1;  res = prod_q[WIDTH-1:0];  ovf = |prod_q[2*WIDTH-1:WIDTH];
        end else begin
          fin = 1'b1;  res = quot_q;
        end
      end
      S_ERROR: begin
        if (op_hit && opcode == OPC_CA) clear_all = 1'b1;
      end
      default: begin
        // ENTRY and RESULT: an opcode press takes priority over a digit.
        if (op_hit) begin
          case (opcode)
            OPC_CA: clear_all = 1'b1;
            OPC_CE: begin
              entry_d = '0;  cnt_d = '0;  disp_d = '0;  state_d = S_ENTRY;
            end
            OPC_EQ: begin
              if (pend_q != OPC_NONE) begin
                start_eval = 1'b1;  next_op_d = OPC_EQ;
              end else if (state_q == S_ENTRY) begin
                disp_d = entry_q;
              end
            end
            default: begin
              if (state_q == S_RESULT) begin
                // The previous result is already in acc.
                pend_d = opcode;  entry_d = '0;  cnt_d = '0;
                disp_d = acc_q;  state_d = S_ENTRY;
              end else if (pend_q == OPC_NONE) begin
                acc_d = entry_q;  pend_d = opcode;  entry_d = '0;
                cnt_d = '0;  disp_d = entry_q;
              end else begin
                start_eval = 1'b1;  next_op_d = opcode;
              end
            end
          endcase
        end else if (digit_hit && cnt_q < CW'(MAX_DIGITS)) begin
          entry_d = entry_next;  cnt_d = cnt_q + 1'b1;
          disp_d  = entry_next;  state_d = S_ENTRY;
        end
      end
    endcase

    if (start_eval) begin
      state_d = S_CALC;  busy_d = 1'b1;  iter_d = '0;
      mcand_d = {{WIDTH{1'b0}}, acc_q};  mplier_d = entry_q;  prod_d = '0;
      rem_d = '0;  quot_d = acc_q;
    end

    if (fin) begin
      busy_d = 1'b0;
      if (ovf) begin
        state_d = S_ERROR;  err_d = 1'b1;  disp_d = '0;
      end else begin
        acc_d = res;  disp_d = res;  entry_d = '0;  cnt_d = '0;
        pend_d  = (next_op_q == OPC_EQ) ? OPC_NONE : next_op_q;
        state_d = (next_op_q == OPC_EQ) ? S_RESULT : S_ENTRY;
      end
    end

    if (clear_all) begin
      state_d = S_ENTRY;  acc_d = '0;  entry_d = '0;  disp_d = '0;
      mplier_d = '0;  quot_d = '0;  rem_d = '0;  mcand_d = '0;  prod_d = '0;
      pend_d = OPC_NONE;  next_op_d = OPC_NONE;  cnt_d = '0;  iter_d = '0;
      busy_d = 1'b0;  err_d = 1'b0;
    end
  end

  // State registers; reset clears everything at once, so no partial result survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ENTRY;  acc_q <= '0;  entry_q <= '0;  disp_q <= '0;
      mplier_q <= '0;  quot_q <= '0;  rem_q <= '0;  mcand_q <= '0;  prod_q <= '0;
      pend_q <= OPC_NONE;  next_op_q <= OPC_NONE;  op_prev_q <= OPC_NONE;
      cnt_q <= '0;  iter_q <= '0;  btn_prev_q <= '0;  busy_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  acc_q <= acc_d;  entry_q <= entry_d;  disp_q <= disp_d;
      mplier_q <= mplier_d;  quot_q <= quot_d;  rem_q <= rem_d;  mcand_q <= mcand_d;
      prod_q <= prod_d;  pend_q <= pend_d;  next_op_q <= next_op_d;
      op_prev_q <= op_prev_d;  cnt_q <= cnt_d;  iter_q <= iter_d;
      btn_prev_q <= btn_prev_d;  busy_q <= busy_d;  err_q <= err_d;
    end
  end

  assign displayedNum = disp_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine: each task drives one scenario and checks
// the display, busy and err outputs against hand-computed values.
module tb_calc_engine;

  localparam logic [2:0] EQ = 3'd1, ADD = 3'd2, SUB = 3'd3, MUL = 3'd4, DIV = 3'd5, CE = 3'd6, CA = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  btn = '0;
  logic [2:0]  opcode = '0;
  logic [31:0] displayedNum;
  logic        busy, err;
  int          total = 0;
  int          bad = 0;

  calc_engine #(.WIDTH(32), .MAX_DIGITS(9)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .opcode(opcode),
    .displayedNum(displayedNum), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_digit(input int d);
    btn = 10'd1 << d;
    tick();
    btn = '0;
    tick();
  endtask

  task automatic enter_num(input int unsigned v);
    int unsigned digs[10];
    int k = 0;
    do begin
      digs[k] = v % 10;
      v = v / 10;
      k++;
    end while (v != 0);
    for (int i = k - 1; i >= 0; i--) press_digit(int'(digs[i]));
  endtask

  task automatic start_op(input logic [2:0] o);
    opcode = o;
    tick();
    opcode = '0;
  endtask

  // Counts sampled busy cycles (bounded), then gives one idle cycle.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    tick();
  endtask

  task automatic do_op(input logic [2:0] o, output int n);
    start_op(o);
    wait_idle(n);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++; if (displayedNum !== 32'd0) begin bad++; $display("FAIL reset_disp: got %0d want 0", displayedNum); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_add();
    int n;
    press_digit(5);
    total++; if (displayedNum !== 32'd5) begin bad++; $display("FAIL add_digit5: got %0d want 5", displayedNum); end
    start_op(ADD);
    total++; if (busy !== 1'b0 || displayedNum !== 32'd5) begin bad++; $display("FAIL add_first_op: got busy=%b disp=%0d want busy=0 disp=5", busy, displayedNum); end
    wait_idle(n);
    press_digit(3);
    total++; if (displayedNum !== 32'd3) begin bad++; $display("FAIL add_digit3: got %0d want 3", displayedNum); end
    start_op(EQ);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy_on: got %b want 1", busy); end
    tick();
    total++; if (busy !== 1'b0 || displayedNum !== 32'd8 || err !== 1'b0) begin bad++; $display("FAIL add_result: got busy=%b disp=%0d err=%b want busy=0 disp=8 err=0", busy, displayedNum, err); end
    tick();
    $display("5 + 3 = %0d", displayedNum);
  endtask

  task automatic test_borrow();
    int n;
    do_op(CA, n);
    enter_num(7); do_op(SUB, n); enter_num(9); do_op(EQ, n);
    total++; if (err !== 1'b1 || displayedNum !== 32'd0) begin bad++; $display("FAIL borrow_err: got err=%b disp=%0d want err=1 disp=0", err, displayedNum); end
    press_digit(4);
    total++; if (err !== 1'b1 || displayedNum !== 32'd0) begin bad++; $display("FAIL borrow_digit_ignored: got err=%b disp=%0d want err=1 disp=0", err, displayedNum); end
    do_op(CA, n);
    total++; if (err !== 1'b0 || displayedNum !== 32'd0) begin bad++; $display("FAIL borrow_clear: got err=%b disp=%0d want err=0 disp=0", err, displayedNum); end
    $display("7 - 9 raised err, cleared");
  endtask

  task automatic test_mul();
    int n;
    enter_num(12); do_op(MUL, n); enter_num(34);
    start_op(EQ); wait_idle(n);
    total++; if (n !== 33) begin bad++; $display("FAIL mul_busy_cycles: got %0d want 33", n); end
    total++; if (displayedNum !== 32'd408) begin bad++; $display("FAIL mul_result: got %0d want 408", displayedNum); end
    do_op(CA, n);
    enter_num(65536); do_op(MUL, n); enter_num(65536); do_op(EQ, n);
    total++; if (err !== 1'b1 || displayedNum !== 32'd0) begin bad++; $display("FAIL mul_overflow: got err=%b disp=%0d want err=1 disp=0", err, displayedNum); end
    do_op(CA, n);
    $display("12 * 34 = 408 in %0d busy cycles; 65536^2 overflows", 33);
  endtask

  task automatic test_div();
    int n;
    enter_num(100); do_op(DIV, n); enter_num(0);
    start_op(EQ);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL div0_busy: got %b want 1", busy); end
    tick();
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL div0_err: got err=%b busy=%b want err=1 busy=0", err, busy); end
    tick();
    do_op(CA, n);
    enter_num(100); do_op(DIV, n); enter_num(7); do_op(EQ, n);
    total++; if (displayedNum !== 32'd14 || err !== 1'b0) begin bad++; $display("FAIL div_result: got disp=%0d err=%b want disp=14 err=0", displayedNum, err); end
    do_op(CA, n);
    $display("100 / 0 errors, 100 / 7 = 14");
  endtask

  task automatic test_digits();
    int n;
    repeat (10) press_digit(1);
    total++; if (displayedNum !== 32'd111111111) begin bad++; $display("FAIL digits_max: got %0d want 111111111", displayedNum); end
    btn = 10'b0000001010; tick(); btn = '0; tick();
    total++; if (displayedNum !== 32'd111111111) begin bad++; $display("FAIL digits_chord: got %0d want 111111111", displayedNum); end
    do_op(CE, n);
    total++; if (displayedNum !== 32'd0) begin bad++; $display("FAIL digits_ce: got %0d want 0", displayedNum); end
    do_op(CA, n);
    enter_num(5); do_op(ADD, n); enter_num(6); do_op(CE, n); enter_num(2); do_op(EQ, n);
    total++; if (displayedNum !== 32'd7) begin bad++; $display("FAIL ce_keeps_pending: got %0d want 7", displayedNum); end
    do_op(CA, n);
    $display("digit limit, chord and clear-entry done");
  endtask

  task automatic test_chain();
    int n;
    enter_num(2); do_op(ADD, n); enter_num(3);
    start_op(MUL); wait_idle(n);
    total++; if (n !== 1 || displayedNum !== 32'd5) begin bad++; $display("FAIL chain_partial: got busy_cycles=%0d disp=%0d want 1 and 5", n, displayedNum); end
    enter_num(4); do_op(EQ, n);
    total++; if (displayedNum !== 32'd20) begin bad++; $display("FAIL chain_result: got %0d want 20", displayedNum); end
    do_op(CA, n);
    $display("2 + 3 * 4 chained = 20");
  endtask

  task automatic test_same_edge();
    int n;
    btn = 10'd1 << 9; opcode = ADD; tick();
    total++; if (displayedNum !== 32'd0) begin bad++; $display("FAIL same_edge_op_wins: got %0d want 0", displayedNum); end
    btn = '0; opcode = '0; tick();
    enter_num(3); do_op(EQ, n);
    total++; if (displayedNum !== 32'd3) begin bad++; $display("FAIL same_edge_result: got %0d want 3", displayedNum); end
    do_op(CA, n);
    $display("digit+op same edge: op taken");
  endtask

  task automatic test_busy_drop();
    int n;
    enter_num(2); do_op(MUL, n); enter_num(3);
    start_op(EQ);
    btn = 10'd1 << 7;
    wait_idle(n);
    total++; if (displayedNum !== 32'd6) begin bad++; $display("FAIL busy_drop_result: got %0d want 6", displayedNum); end
    btn = '0; tick(); tick();
    total++; if (displayedNum !== 32'd6) begin bad++; $display("FAIL busy_drop_lost: got %0d want 6", displayedNum); end
    do_op(CA, n);
    $display("key pressed during busy was dropped");
  endtask

  task automatic test_reset_mid();
    int n;
    enter_num(12); do_op(MUL, n); enter_num(34);
    start_op(EQ);
    repeat (9) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (displayedNum !== 32'd0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_immediate: got disp=%0d busy=%b want 0 0", displayedNum, busy); end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    total++; if (displayedNum !== 32'd0 || busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL midrst_no_result: got disp=%0d busy=%b err=%b want 0 0 0", displayedNum, busy, err); end
    $display("reset during multiply discarded the result");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_borrow();
    test_mul();
    test_div();
    test_digits();
    test_chain();
    test_same_edge();
    test_busy_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_engine.md
# calc_engine

Parametrised, clocked successor to the calculator datapath. It takes held one-hot digit buttons and a 3-bit opcode. It edge-detects key presses, builds a decimal operand, and evaluates chained unsigned add/sub/mul/div with multi-cycle multiply and divide. It drives a WIDTH-bit display value plus busy and error flags, and sits between the board's button/switch inputs and the display driver.

## Interface
- WIDTH, 32, operand/accumulator/display width in bits.
- MAX_DIGITS, 9, maximum decimal digits per operand; integrator guarantees 10^MAX_DIGITS-1 < 2^WIDTH.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn  input  10  held digit keys, bit d = digit d.
- opcode  input  3  held operator: 000 none, 001 equals, 010 add, 011 sub, 100 mul, 101 div, 110 clear-entry, 111 clear-all.
- displayedNum  output  WIDTH  value shown: current entry, accumulator, or result.
- busy  output  1  high while an evaluation is in progress.
- err  output  1  sticky error (overflow, borrow, divide by zero).

## Operation
- Registers: acc, entry, pending_op (NONE/ADD/SUB/MUL/DIV), digit count, btn_prev, op_prev, state.
- Digit press: sampled at an edge where btn_prev==0 and btn is one-hot. If more than one bit is set, the press is ignored. If digit count < MAX_DIGITS: entry <= entry*10 + d, count++, display entry. Otherwise the press is ignored.
- Op press: sampled at an edge where op_prev==000 and opcode!=000.
- Operator (add/sub/mul/div):
  - If pending_op==NONE: acc <= entry.
  - Otherwise: evaluate acc pending_op entry -> acc (chaining).
  - Then pending_op <= new op, entry <= 0, count <= 0, display acc.
- Equals:
  - If pending_op==NONE: display entry.
  - Otherwise: evaluate, display result, pending_op <= NONE, state RESULT.
  - In RESULT, a digit starts a fresh entry (count 1). An operator uses the result as acc.
- Clear-entry: entry <= 0, count <= 0, display 0. pending_op and acc are unchanged.
- Clear-all: every register returns to its reset value. Clear-all is the only exit from ERROR.
- Arithmetic is unsigned mod 2^WIDTH:
  - add: err on carry-out.
  - sub: err on borrow (acc < entry).
  - mul: iterative shift-add, one bit per cycle. err if any of the upper WIDTH bits of the 2*WIDTH product are nonzero.
  - div: iterative restoring, quotient only, one bit per cycle. Divisor 0 -> err, detected before iterating.
- Any error: state ERROR, err=1, displayedNum=0. Digits and every opcode except clear-all are ignored.
- While busy=1, all new presses are dropped. btn_prev and op_prev still update, so a key first pressed during busy is lost, not deferred.
- State machine:
  - ENTRY -> CALC on operator/equals with a pending op.
  - CALC -> ENTRY (after operator) / RESULT (after equals) / ERROR.
  - RESULT -> ENTRY on digit or operator.
  - ERROR -> ENTRY on clear-all.

## Timing
- Reset (async assert, sync-safe release): displayedNum=0, busy=0, err=0, acc=entry=0, pending_op=NONE, state ENTRY, btn_prev=op_prev=0.
- Digit press detected at edge N: displayedNum shows the new entry after edge N (0-cycle latency).
- Operator with pending NONE: acc is displayed after edge N; busy is never asserted.
- add/sub evaluation: busy=1 after edge N. Result/acc is displayed and busy=0 after edge N+1.
- mul/div evaluation: busy=1 after edge N. Result is displayed and busy=0 after edge N+WIDTH+1.
- Divide by zero: err=1 and busy=0 after edge N+1.
- A digit and an opcode press at the same edge: the opcode is processed and the digit is dropped.
- rst_n low mid-evaluation: outputs return to reset values immediately (asynchronous). No partial result is ever displayed.

## Test plan
- Reset; press btn[5], release; opcode 010; release; btn[3]; opcode 001 -> display 5, 5, 3, 8; busy pulses 1 cycle; err=0.
- 7, sub, 9, equals -> err=1, display 0. Digit 4 -> still 0. opcode 111 -> err=0, display 0.
- 12, mul, 34, equals -> busy high exactly 33 cycles (WIDTH=32), display 408. 65536 mul 65536 -> err=1.
- 100, div, 0, equals -> err=1 after 1 busy cycle. Clear-all; 100, div, 7, equals -> display 14.
- Press 1 ten times -> display 111111111. btn=0000001010 -> ignored. Opcode 110 -> display 0, pending op kept.
- 2, add, 3, mul (display 5), 4, equals -> 20. Start 12 mul 34, deassert rst_n at busy cycle 10 -> display 0, busy 0 immediately, no result afterwards.
